// File: rtl/multicycle_adder.sv
// Multi-cycle adder/subtractor. It processes SLICE bits per clock, lowest slice
// first, and carries between slices in a register.
// An operation takes N = WIDTH_A/SLICE clocks from the start edge to the done pulse.
module multicycle_adder #(
    parameter int WIDTH_A = 32,
    parameter int WIDTH_B = 16,
    parameter int SLICE   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  logic [WIDTH_A-1:0] op_a,
    input  logic [WIDTH_B-1:0] op_b,
    input  logic               sub,
    input  logic               sign_ext,
    output logic               busy,
    output logic               done,
    output logic [WIDTH_A-1:0] result,
    output logic               carry_out,
    output logic               overflow
);

    localparam int N  = WIDTH_A / SLICE;
    localparam int CW = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    // Reject parameter sets the datapath cannot represent.
    generate
        if (WIDTH_B < 1 || WIDTH_B > WIDTH_A) begin : g_bad_wb
            $error("multicycle_adder: WIDTH_B must be in 1..WIDTH_A");
        end
        if (SLICE < 1 || (WIDTH_A % SLICE) != 0) begin : g_bad_slice
            $error("multicycle_adder: WIDTH_A must be a multiple of SLICE");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

    state_t             state_q;
    logic [CW-1:0]      cnt_q;
    logic [WIDTH_A-1:0] a_q;
    logic [WIDTH_A-1:0] b_q;       // op_b after extension and optional inversion
    logic               carry_q;   // carry into the current slice
    logic [WIDTH_A-1:0] sum_q;     // partial sum, filled in slice by slice
    logic [WIDTH_A-1:0] result_q;
    logic               carry_out_q;
    logic               overflow_q;
    logic               busy_q;
    logic               done_q;

    logic [WIDTH_A-1:0] b_ext;
    logic [WIDTH_A-1:0] b_mask;
    logic [SLICE-1:0]   a_sl;
    logic [SLICE-1:0]   b_sl;
    logic [SLICE:0]     sl_sum;
    logic               c_msb_in;
    logic [WIDTH_A-1:0] sum_d;

    // Extend op_b to the datapath width. The mask covers the bits above
    // WIDTH_B. It is empty when WIDTH_B == WIDTH_A because the shift wraps to 0.
    always_comb begin
        b_mask = ~((WIDTH_A'(1) << WIDTH_B) - WIDTH_A'(1));
        b_ext  = WIDTH_A'(op_b);
        if (sign_ext && op_b[WIDTH_B-1]) begin
            b_ext = b_ext | b_mask;
        end
    end

    // Add one slice. The carry into the slice MSB is recovered from the sum
    // bit, so overflow can be formed when the top slice is added.
    always_comb begin
        a_sl     = a_q[cnt_q*SLICE +: SLICE];
        b_sl     = b_q[cnt_q*SLICE +: SLICE];
        sl_sum   = {1'b0, a_sl} + {1'b0, b_sl} + (SLICE+1)'(carry_q);
        c_msb_in = a_sl[SLICE-1] ^ b_sl[SLICE-1] ^ sl_sum[SLICE-1];
        sum_d    = sum_q;
        sum_d[cnt_q*SLICE +: SLICE] = sl_sum[SLICE-1:0];
    end

    // Control FSM and datapath registers. Results update only on the last slice.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            carry_q     <= 1'b0;
            sum_q       <= '0;
            result_q    <= '0;
            carry_out_q <= 1'b0;
            overflow_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= op_a;
                        b_q     <= sub ? ~b_ext : b_ext;
                        carry_q <= sub;
                        cnt_q   <= '0;
                        sum_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= RUN;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    sum_q   <= sum_d;
                    carry_q <= sl_sum[SLICE];
                    cnt_q   <= cnt_q + CW'(1);
                    if (cnt_q == LAST) begin
                        result_q    <= sum_d;
                        carry_out_q <= sl_sum[SLICE];
                        overflow_q  <= sl_sum[SLICE] ^ c_msb_in;
                        busy_q      <= 1'b0;
                        done_q      <= 1'b1;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign carry_out = carry_out_q;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_multicycle_adder.sv
// Directed bench for multicycle_adder using the default 32/16/8 configuration.
module tb_multicycle_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [15:0] op_b;
    logic        sub;
    logic        sign_ext;
    logic        busy;
    logic        done;
    logic [31:0] result;
    logic        carry_out;
    logic        overflow;

    int n_pass = 0;
    int n_tot  = 0;

    multicycle_adder #(.WIDTH_A(32), .WIDTH_B(16), .SLICE(8)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .op_a(op_a), .op_b(op_b),
        .sub(sub), .sign_ext(sign_ext), .busy(busy), .done(done),
        .result(result), .carry_out(carry_out), .overflow(overflow)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [15:0] b;
        logic        sb;
        logic        sx;
        logic [31:0] res;
        logic        co;
        logic        ov;
    } vec_t;

    vec_t vecs[8];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    // Launch one operation and follow it to done. The cycle budget is bounded.
    // busy_n counts busy samples after edges 1.. before done. With N=4, busy is
    // high over the 3 interior edges between the start edge and the done edge.
    task automatic run_op(input logic [31:0] a, input logic [15:0] b, input logic sb,
                          input logic sx, output int lat, output int busy_n,
                          output logic held);
        logic [31:0] r0;
        @(negedge clk);
        op_a = a; op_b = b; sub = sb; sign_ext = sx; start = 1'b1;
        r0 = result;
        @(posedge clk); #1;
        start = 1'b0;
        op_a = $urandom; op_b = 16'($urandom); sub = ~sb; sign_ext = ~sx;
        chk("busy_after_start", {63'd0, busy}, 64'd1);
        lat = 0; busy_n = 0; held = 1'b1;
        while (lat < 20) begin
            @(posedge clk); #1;
            lat++;
            if (done) break;
            if (busy) busy_n++;
            if (result !== r0) held = 1'b0;
        end
        chk("busy_low_at_done", {63'd0, busy}, 64'd0);
    endtask

    initial begin
        int   lat, bn;
        logic held;
        logic seen;

        vecs[0] = '{32'h00001000, 16'h0010, 1'b0, 1'b0, 32'h00001010, 1'b0, 1'b0};
        vecs[1] = '{32'h00001000, 16'hFFF0, 1'b0, 1'b1, 32'h00000FF0, 1'b1, 1'b0};
        vecs[2] = '{32'h00001000, 16'hFFF0, 1'b0, 1'b0, 32'h00010FF0, 1'b0, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 16'h0001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h00000005, 16'h0007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 16'h0001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{32'hFFFFFFFF, 16'h0001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[7] = '{32'h00000003, 16'hFFFF, 1'b1, 1'b1, 32'h00000004, 1'b0, 1'b0};

        rst_n = 1'b0; start = 1'b0; op_a = '0; op_b = '0; sub = 1'b0; sign_ext = 1'b0;
        #1;
        chk("reset_outputs", {29'd0, busy, done, carry_out, overflow, result}, 64'd0);
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;

        // Table-driven vectors.
        foreach (vecs[i]) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].sb, vecs[i].sx, lat, bn, held);
            chk($sformatf("v%0d_latency", i), 64'(lat), 64'd4);
            chk($sformatf("v%0d_result", i), {32'd0, result}, {32'd0, vecs[i].res});
            chk($sformatf("v%0d_carry", i), {63'd0, carry_out}, {63'd0, vecs[i].co});
            chk($sformatf("v%0d_overflow", i), {63'd0, overflow}, {63'd0, vecs[i].ov});
            chk($sformatf("v%0d_hold_in_run", i), {63'd0, held}, 64'd1);
            if (i == 0) chk("v0_busy_edges", 64'(bn), 64'd3);
        end

        // Start during RUN is ignored. A start in the DONE cycle chains immediately.
        @(negedge clk);
        op_a = 32'h00001000; op_b = 16'h0010; sub = 1'b0; sign_ext = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        @(posedge clk); #1;
        op_a = 32'hDEADBEEF; op_b = 16'h1234; sub = 1'b1; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("ign_busy", {62'd0, busy, done}, 64'd2);
        @(posedge clk); #1;
        chk("ign_no_early_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1;
        chk("ign_done", {63'd0, done}, 64'd1);
        chk("ign_result", {32'd0, result}, 64'h00001010);
        op_a = 32'h7FFFFFFF; op_b = 16'h0001; sub = 1'b0; sign_ext = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        chk("b2b_busy", {62'd0, busy, done}, 64'd2);
        held = 1'b1; seen = 1'b0;
        repeat (3) begin
            @(posedge clk); #1;
            if (result !== 32'h00001010) held = 1'b0;
            if (done) seen = 1'b1;
        end
        chk("b2b_hold_first", {63'd0, held}, 64'd1);
        chk("b2b_no_early_done", {63'd0, seen}, 64'd0);
        @(posedge clk); #1;
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_result", {30'd0, carry_out, overflow, result}, {30'd0, 2'b01, 32'h80000000});

        // Reset in the middle of an operation: outputs clear at once and no done follows.
        @(negedge clk);
        op_a = 32'hFFFFFFFF; op_b = 16'h0001; sub = 1'b0; start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_run", {29'd0, busy, done, carry_out, overflow, result}, 64'd0);
        seen = 1'b0;
        repeat (4) begin @(posedge clk); #1; if (done || busy) seen = 1'b1; end
        chk("rst_no_done", {63'd0, seen}, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        chk("rst_still_idle", {62'd0, busy, done}, 64'd0);
        run_op(vecs[0].a, vecs[0].b, 1'b0, 1'b0, lat, bn, held);
        chk("post_rst_latency", 64'(lat), 64'd4);
        chk("post_rst_result", {31'd0, carry_out, result}, {31'd0, 1'b0, 32'h00001010});

        @(posedge clk); #1;
        chk("idle_after_done", {62'd0, busy, done}, 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
